// File: rtl/nn_pkg.sv
// Shared fixed-point constants, saturation helper and sequencer state encoding
// for the neuron datapath; reused by the layer controller.
package nn_pkg;

    localparam int NN_FRAC_BITS = 16;
    localparam int DATA_W       = 32;

    localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_BIAS,
        ST_FINISH
    } mac_state_e;

    // Clamp a sign-extended accumulator value to the signed 32-bit range.
    function automatic logic [DATA_W-1:0] sat32(input logic signed [63:0] v);
        if (v > 64'sh0000_0000_7FFF_FFFF) begin
            return SAT_MAX;
        end else if (v < 64'shFFFF_FFFF_8000_0000) begin
            return SAT_MIN;
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/neuron_mac_ctrl_if.sv
// Bundle between the neuron sequencer and its layer controller / memories.
// master = layer side (drives start, bias and memory read data); slave = neuron.
interface neuron_mac_ctrl_if;
    import nn_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rd_addr;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] x_data;
    logic [DATA_W-1:0] bias;
    logic [DATA_W-1:0] result;

    modport master (
        output start, w_data, x_data, bias,
        input  busy, done, rd_addr, result
    );

    modport slave (
        input  start, w_data, x_data, bias,
        output busy, done, rd_addr, result
    );

endinterface

// File: rtl/neuron_mac_ctrl_fx_mul_shift.sv
// Registered signed 32x32 multiply rescaled by >>FRAC_BITS to the accumulator width.
// One cycle latency; clr wins over en, and the register holds when en is low.
module fx_mul_shift
    import nn_pkg::*;
#(
    parameter int FRAC_BITS = NN_FRAC_BITS,
    parameter int ACC_W     = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic [DATA_W-1:0]       a,
    input  logic [DATA_W-1:0]       b,
    output logic signed [ACC_W-1:0] prod,
    output logic                    prod_vld
);

    logic signed [63:0]      full;
    logic signed [63:0]      scaled;
    logic signed [ACC_W-1:0] prod_d, prod_q;
    logic                    vld_d, vld_q;

    always_comb begin
        full   = 64'($signed(a)) * 64'($signed(b));
        scaled = full >>> FRAC_BITS;
        prod_d = prod_q;
        vld_d  = vld_q;
        if (clr) begin
            prod_d = '0;
            vld_d  = 1'b0;
        end else if (en) begin
            prod_d = scaled[ACC_W-1:0];
            vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            vld_q  <= vld_d;
        end
    end

    assign prod     = prod_q;
    assign prod_vld = vld_q;

endmodule

// File: rtl/neuron_mac_ctrl.sv
// Walks the weight/input address space, accumulates the Q16.16 dot product plus bias
// and presents a saturated result with a one-cycle done pulse; start is ignored while busy.
module neuron_mac_ctrl
    import nn_pkg::*;
#(
    parameter int NUM_INPUTS = 784,
    parameter int FRAC_BITS  = NN_FRAC_BITS,
    parameter int ACC_W      = 48
) (
    input  logic             clk,
    input  logic             rst,
    neuron_mac_ctrl_if.slave bus
);

    localparam logic [DATA_W-1:0] LAST_ADDR = DATA_W'(NUM_INPUTS - 1);

    mac_state_e              state_d, state_q;
    logic [DATA_W-1:0]       addr_d, addr_q;
    logic signed [ACC_W-1:0] acc_d, acc_q;
    logic [DATA_W-1:0]       result_d, result_q;
    logic                    done_d, done_q;

    logic                    mul_clr;
    logic                    mul_en;
    logic signed [ACC_W-1:0] prod;
    logic                    prod_vld;

    fx_mul_shift #(
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .clr      (mul_clr),
        .en       (mul_en),
        .a        (bus.w_data),
        .b        (bus.x_data),
        .prod     (prod),
        .prod_vld (prod_vld)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;
        mul_clr  = 1'b0;
        mul_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    addr_d  = '0;
                    acc_d   = '0;
                    mul_clr = 1'b1;
                end
            end
            ST_RUN: begin
                // The product register lags the address by one cycle.
                mul_en = 1'b1;
                if (prod_vld) begin
                    acc_d = acc_q + prod;
                end
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                acc_d   = acc_q + prod;
                state_d = ST_BIAS;
            end
            ST_BIAS: begin
                acc_d   = acc_q + ACC_W'($signed(bus.bias));
                state_d = ST_FINISH;
            end
            ST_FINISH: begin
                result_d = sat32(64'(acc_q));
                done_d   = 1'b1;
                addr_d   = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = done_q;
    assign bus.rd_addr = addr_q;
    assign bus.result  = result_q;

endmodule
